// File: rtl/spart_pkg.sv
// Shared constants for the SPART bus responder: register map, default
// baud divisor and queue depth.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_DBL  = 2'd2;
  localparam logic [1:0] ADDR_DBH  = 2'd3;

  // 50 MHz clock, 9600 baud, 16x oversampling
  localparam logic [15:0] DIV_DEFAULT = 16'd325;

  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 4;

  // Status byte layout: free TX slots in the high nibble, RX fill in the low.
  function automatic logic [7:0] make_status(input logic [CNT_W-1:0] tx_free,
                                             input logic [CNT_W-1:0] rx_count);
    return {tx_free, rx_count};
  endfunction

endpackage

// File: rtl/spart_bus_if_if.sv
// CPU bus control lines and TX/RX engine handshakes for the SPART responder.
// The shared databus stays a plain inout port on the responder.
interface spart_bus_if_if;

  logic       iocs_n;
  logic       iorw_n;
  logic [1:0] ioaddr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  // CPU and shift-engine side
  modport master (
    output iocs_n, iorw_n, ioaddr, tx_ready, rx_data, rx_valid,
    input  tx_data, tx_valid
  );

  // Responder side
  modport slave (
    input  iocs_n, iorw_n, ioaddr, tx_ready, rx_data, rx_valid,
    output tx_data, tx_valid
  );

endinterface

// File: rtl/spart_fifo.sv
// Synchronous byte FIFO. A push is refused when full and a pop is refused
// when empty, judged on the state at the start of the cycle.
module spart_fifo
  import spart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]    LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage array; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/spart_bus_if.sv
// SPART memory-mapped responder: decodes CPU accesses, holds the TX/RX byte
// queues and the baud divisor, and drives the shared databus on reads.
module spart_bus_if
  import spart_pkg::*;
#(
  parameter int          DEPTH     = FIFO_DEPTH,
  parameter logic [15:0] DIV_RESET = DIV_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  spart_bus_if_if.slave  bus,
  inout  wire  [7:0]     databus,
  output logic [15:0]    baud_div,
  output logic           tx_q_full,
  output logic           rx_q_empty
);

  logic             cpu_rd;
  logic             cpu_wr;
  logic             tx_push;
  logic             tx_empty;
  logic [CNT_W-1:0] tx_count;
  logic [CNT_W-1:0] tx_free;
  logic             rx_pop;
  logic             rx_push;
  logic             rx_full;
  logic [7:0]       rx_head;
  logic [CNT_W-1:0] rx_count;
  logic [7:0]       rd_data;

  assign cpu_rd  = ~bus.iocs_n & bus.iorw_n;
  assign cpu_wr  = ~bus.iocs_n & ~bus.iorw_n;
  assign tx_push = cpu_wr & (bus.ioaddr == ADDR_DATA) & ~tx_q_full;
  assign rx_pop  = cpu_rd & (bus.ioaddr == ADDR_DATA) & ~rx_q_empty;
  assign rx_push = bus.rx_valid & ~rx_full;
  assign tx_free = CNT_W'(DEPTH) - tx_count;

  assign bus.tx_valid = ~tx_empty;

  spart_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (databus),
    .pop       (bus.tx_ready),
    .head      (bus.tx_data),
    .full      (tx_q_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  spart_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (bus.rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_q_empty),
    .count     (rx_count)
  );

  // Divisor register, written a byte at a time
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_div <= DIV_RESET;
    end else if (cpu_wr && bus.ioaddr == ADDR_DBL) begin
      baud_div[7:0] <= databus;
    end else if (cpu_wr && bus.ioaddr == ADDR_DBH) begin
      baud_div[15:8] <= databus;
    end
  end

  // Read mux; an empty RX queue reads as zero
  always_comb begin
    rd_data = 8'h00;
    case (bus.ioaddr)
      ADDR_DATA: rd_data = rx_q_empty ? 8'h00 : rx_head;
      ADDR_STAT: rd_data = make_status(tx_free, rx_count);
      ADDR_DBL:  rd_data = baud_div[7:0];
      ADDR_DBH:  rd_data = baud_div[15:8];
      default:   rd_data = 8'h00;
    endcase
  end

  assign databus = cpu_rd ? rd_data : 8'hzz;

endmodule

// File: tb/tb_spart_bus_if.sv
// Scoreboard bench for the SPART bus responder.
module tb_spart_bus_if;
  import spart_pkg::*;

  localparam int DEPTH = FIFO_DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  wire  [7:0]  databus;
  logic        tb_oe;
  logic [7:0]  tb_wdata;
  logic [15:0] baud_div;
  logic        tx_q_full;
  logic        rx_q_empty;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_sb[$];
  logic [7:0] rx_sb[$];

  spart_bus_if_if bus_if ();

  assign databus = tb_oe ? tb_wdata : 8'hzz;

  spart_bus_if #(.DEPTH(DEPTH), .DIV_RESET(16'd325)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if.slave),
    .databus    (databus),
    .baud_div   (baud_div),
    .tx_q_full  (tx_q_full),
    .rx_q_empty (rx_q_empty)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic idle_bus();
    bus_if.iocs_n = 1'b1;
    bus_if.iorw_n = 1'b1;
    bus_if.ioaddr = 2'd0;
    tb_oe         = 1'b0;
    tb_wdata      = 8'h00;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    bus_if.iocs_n = 1'b0;
    bus_if.iorw_n = 1'b0;
    bus_if.ioaddr = a;
    tb_wdata      = d;
    tb_oe         = 1'b1;
    if (a == ADDR_DATA && tx_sb.size() < DEPTH) tx_sb.push_back(d);
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    bus_if.iocs_n = 1'b0;
    bus_if.iorw_n = 1'b1;
    bus_if.ioaddr = a;
    @(negedge clk);
    d = databus;
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic rx_strobe(input logic [7:0] d);
    bus_if.rx_data  = d;
    bus_if.rx_valid = 1'b1;
    if (rx_sb.size() < DEPTH) rx_sb.push_back(d);
    @(posedge clk); #1;
    bus_if.rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] model_status();
    return {4'(DEPTH - tx_sb.size()), 4'(rx_sb.size())};
  endfunction

  task automatic drain_tx();
    logic [7:0] exp;
    bus_if.tx_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      @(negedge clk);
      if (!bus_if.tx_valid) break;
      checks++;
      if (tx_sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL tx_drain_extra actual=%h required=<none>", bus_if.tx_data);
      end else begin
        exp = tx_sb.pop_front();
        if (bus_if.tx_data !== exp) begin
          errors++;
          $display("[TB] FAIL tx_drain_data actual=%h required=%h", bus_if.tx_data, exp);
        end
      end
      @(posedge clk); #1;
    end
    bus_if.tx_ready = 1'b0;
    checks++;
    if (tx_sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL tx_drain_left actual=%0d required=0", tx_sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    idle_bus();
    bus_if.tx_ready = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tx_sb.delete();
    rx_sb.delete();
    @(negedge clk);
    checks++;
    if (rx_q_empty !== 1'b1 || bus_if.tx_valid !== 1'b0 || tx_q_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags actual=%b%b%b required=100", rx_q_empty, bus_if.tx_valid, tx_q_full);
    end
    checks++;
    if (baud_div !== 16'd325) begin
      errors++;
      $display("[TB] FAIL reset_baud actual=%h required=%h", baud_div, 16'd325);
    end
    @(posedge clk); #1;
    cpu_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h80) begin
      errors++;
      $display("[TB] FAIL reset_status actual=%h required=80", d);
    end
  endtask

  task automatic test_tx_single();
    cpu_write(ADDR_DATA, 8'hA5);
    @(negedge clk);
    checks++;
    if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL tx_single actual=%b/%h required=1/a5", bus_if.tx_valid, bus_if.tx_data);
    end
    @(posedge clk); #1;
    drain_tx();
    checks++;
    if (bus_if.tx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tx_single_empty actual=%b required=0", bus_if.tx_valid);
    end
  endtask

  task automatic test_tx_full();
    logic [7:0] d;
    for (int i = 1; i <= 9; i++) begin
      cpu_write(ADDR_DATA, 8'(i));
      if (i == 7 || i == 8) begin
        checks++;
        if (tx_q_full !== (i == 8)) begin
          errors++;
          $display("[TB] FAIL tx_full_after_%0d actual=%b required=%b", i, tx_q_full, (i == 8));
        end
      end
    end
    cpu_read(ADDR_STAT, d);
    checks++;
    if (d !== model_status()) begin
      errors++;
      $display("[TB] FAIL tx_full_status actual=%h required=%h", d, model_status());
    end
    drain_tx();
  endtask

  task automatic test_rx();
    logic [7:0] d;
    logic [7:0] exp;
    rx_strobe(8'h3C);
    checks++;
    if (rx_q_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rx_empty_fall actual=%b required=0", rx_q_empty);
    end
    rx_strobe(8'hC3);
    cpu_read(ADDR_STAT, d);
    checks++;
    if (d !== model_status()) begin
      errors++;
      $display("[TB] FAIL rx_status actual=%h required=%h", d, model_status());
    end
    for (int i = 0; i < 3; i++) begin
      exp = (rx_sb.size() > 0) ? rx_sb.pop_front() : 8'h00;
      cpu_read(ADDR_DATA, d);
      checks++;
      if (d !== exp) begin
        errors++;
        $display("[TB] FAIL rx_read_%0d actual=%h required=%h", i, d, exp);
      end
      if (i == 1) begin
        checks++;
        if (rx_q_empty !== 1'b1) begin
          errors++;
          $display("[TB] FAIL rx_empty_rise actual=%b required=1", rx_q_empty);
        end
      end
    end
  endtask

  task automatic test_divisor();
    logic [7:0] d;
    cpu_write(ADDR_DBL, 8'h58);
    cpu_write(ADDR_DBH, 8'h14);
    cpu_write(ADDR_STAT, 8'hFF);
    checks++;
    if (baud_div !== 16'h1458) begin
      errors++;
      $display("[TB] FAIL baud_write actual=%h required=1458", baud_div);
    end
    cpu_read(ADDR_DBL, d);
    checks++;
    if (d !== 8'h58) begin
      errors++;
      $display("[TB] FAIL baud_read_lo actual=%h required=58", d);
    end
    cpu_read(ADDR_DBH, d);
    checks++;
    if (d !== 8'h14) begin
      errors++;
      $display("[TB] FAIL baud_read_hi actual=%h required=14", d);
    end
    cpu_read(ADDR_STAT, d);
    checks++;
    if (d !== model_status()) begin
      errors++;
      $display("[TB] FAIL stat_write_ignored actual=%h required=%h", d, model_status());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) cpu_write(ADDR_DATA, 8'h10 + 8'(i));
    bus_if.iocs_n   = 1'b0;
    bus_if.iorw_n   = 1'b0;
    bus_if.ioaddr   = ADDR_DATA;
    tb_wdata        = 8'h20;
    tb_oe           = 1'b1;
    bus_if.tx_ready = 1'b1;
    @(negedge clk);
    exp = tx_sb.pop_front();
    tx_sb.push_back(8'h20);
    checks++;
    if (bus_if.tx_data !== exp) begin
      errors++;
      $display("[TB] FAIL b2b_head actual=%h required=%h", bus_if.tx_data, exp);
    end
    @(posedge clk); #1;
    idle_bus();
    bus_if.tx_ready = 1'b0;
    cpu_read(ADDR_STAT, d);
    checks++;
    if (d !== model_status()) begin
      errors++;
      $display("[TB] FAIL b2b_status actual=%h required=%h", d, model_status());
    end
    drain_tx();
  endtask

  task automatic test_rx_full();
    logic [7:0] d;
    logic [7:0] exp;
    for (int i = 0; i < 9; i++) rx_strobe(8'h40 + 8'(i));
    cpu_read(ADDR_STAT, d);
    checks++;
    if (d !== model_status()) begin
      errors++;
      $display("[TB] FAIL rx_full_status actual=%h required=%h", d, model_status());
    end
    // Read while a new byte arrives on a full queue: pop only
    bus_if.iocs_n   = 1'b0;
    bus_if.iorw_n   = 1'b1;
    bus_if.ioaddr   = ADDR_DATA;
    bus_if.rx_data  = 8'hEE;
    bus_if.rx_valid = 1'b1;
    @(negedge clk);
    exp = rx_sb.pop_front();
    checks++;
    if (databus !== exp) begin
      errors++;
      $display("[TB] FAIL rx_full_pop actual=%h required=%h", databus, exp);
    end
    @(posedge clk); #1;
    bus_if.rx_valid = 1'b0;
    // Held chip select: one pop per cycle, then zeros once empty
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = (rx_sb.size() > 0) ? rx_sb.pop_front() : 8'h00;
      checks++;
      if (databus !== exp) begin
        errors++;
        $display("[TB] FAIL rx_burst_%0d actual=%h required=%h", i, databus, exp);
      end
      @(posedge clk);
    end
    #1 idle_bus();
    checks++;
    if (rx_q_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rx_burst_empty actual=%b required=1", rx_q_empty);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    for (int i = 0; i < 3; i++) cpu_write(ADDR_DATA, 8'h70 + 8'(i));
    rx_strobe(8'h61);
    rx_strobe(8'h62);
    bus_if.iocs_n = 1'b0;
    bus_if.iorw_n = 1'b0;
    bus_if.ioaddr = ADDR_DATA;
    tb_wdata      = 8'hAA;
    tb_oe         = 1'b1;
    rst           = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_bus();
    tx_sb.delete();
    rx_sb.delete();
    checks++;
    if (bus_if.tx_valid !== 1'b0 || rx_q_empty !== 1'b1 || baud_div !== 16'd325) begin
      errors++;
      $display("[TB] FAIL mid_reset_state actual=%b/%b/%h required=0/1/0145", bus_if.tx_valid, rx_q_empty, baud_div);
    end
    cpu_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h80) begin
      errors++;
      $display("[TB] FAIL mid_reset_status actual=%h required=80", d);
    end
  endtask

  // Test sequence
  initial begin
    rst             = 1'b1;
    bus_if.tx_ready = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    idle_bus();
    test_reset();
    test_tx_single();
    test_tx_full();
    test_rx();
    test_divisor();
    test_back_to_back();
    test_rx_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/spart_bus_if.md
# spart_bus_if

Memory-mapped responder for the SPART serial peripheral. It answers CPU bus cycles on the shared `databus` (`iocs_n`, `iorw_n`, `ioaddr`) and holds the 8-entry TX and RX byte queues. It also holds the baud divisor and status register. It sits between the top-level address decode and the SPART serial TX/RX shift engines, handing bytes to and from those engines over valid/ready handshakes.

## Interface
Parameters:
- `DEPTH`, default 8: entries per queue; power of two, at most 8 so each count fits in 4 bits.
- `DIV_RESET`, default 16'd325: baud divisor after reset (50 MHz, 9600 baud, 16x oversample).

Ports:
- `clk`  in  1: system clock. One clock; reset is synchronous and active-high.
- `rst`  in  1: synchronous, active-high reset.
- `iocs_n`  in  1: chip select, active low; one access per cycle while low.
- `iorw_n`  in  1: 1 = CPU read, 0 = CPU write.
- `ioaddr`  in  2: register select. 0 = data, 1 = status, 2 = divisor low, 3 = divisor high.
- `databus`  inout  8: shared bus. Driven by this block only while `iocs_n`=0 and `iorw_n`=1; otherwise high-Z.
- `tx_data`  out  8: head of the TX queue.
- `tx_valid`  out  1: TX queue is non-empty.
- `tx_ready`  in  1: TX engine accepts the head byte this cycle.
- `rx_data`  in  8: byte from the RX engine.
- `rx_valid`  in  1: single-cycle strobe marking `rx_data` as a received byte.
- `baud_div`  out  16: current divisor for the baud generator.
- `tx_q_full`  out  1: TX queue holds `DEPTH` entries.
- `rx_q_empty`  out  1: RX queue holds 0 entries.

## Operation
- Reset values:
  - queues emptied; pointers and counts = 0
  - `tx_valid`=0, `tx_q_full`=0, `rx_q_empty`=1
  - `baud_div`=`DIV_RESET`
  - `databus` high-Z
  - `tx_data` = don't-care while `tx_valid`=0
- Write to addr 0: `databus` is pushed to the TX queue if it was not full at the start of the cycle; otherwise the byte is silently dropped.
- Read from addr 0: returns the RX head combinationally in the same cycle and pops it at the clock edge. If the RX queue is empty, returns 8'h00 and does not pop.
- Read from addr 1: returns status = {tx_free[3:0], rx_count[3:0]}, where tx_free = `DEPTH` − tx_count.
- Write to addr 2 or 3: updates `baud_div[7:0]` or `baud_div[15:8]` at the clock edge. Reads of addr 2/3 return the stored byte.
- Write to addr 1: ignored.
- TX handshake: a pop occurs when `tx_valid` & `tx_ready`.
- RX handshake: `rx_valid` pushes `rx_data` if the RX queue was not full at the start of the cycle; otherwise the byte is dropped.
- Simultaneous push and pop on one queue, not full, not empty: both happen and the count is unchanged.
- When full, a push is refused even if a pop occurs in the same cycle.
- When empty, a pop is refused even if a push occurs in the same cycle.
- Pointer and count arithmetic:
  - pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`
  - counts are 4 bits, range 0..`DEPTH`, and never overflow
- Reset asserted mid-operation: all queued bytes are discarded; state returns to reset values on the next edge.

## Timing
- Read data on `databus` is valid in the same cycle as `iocs_n`=0 (combinational from registered state).
- All state changes occur at the rising edge of `clk`.
- CPU write to `tx_valid`: the pushed byte makes `tx_valid`=1 in the following cycle (1-cycle latency).
- `rx_valid` to read: the received byte is readable in the following cycle, and `rx_q_empty` falls in that cycle.
- `tx_q_full` and `rx_q_empty` are registered-state decodes with no extra delay.
- Holding `iocs_n` low for N cycles performs N accesses; for example, N data reads pop N bytes.

## Structure
- `spart_pkg`:
  - address constants `ADDR_DATA`=2'd0, `ADDR_STAT`=2'd1, `ADDR_DBL`=2'd2, `ADDR_DBH`=2'd3
  - default divisor
  - queue depth
- Sub-module `spart_fifo`: synchronous byte FIFO with push/pop, `full`, `empty`, and `count`. Instantiated twice, once for TX and once for RX.
- Top of block: address decode, divisor register, and the `databus` tri-state.

## Test plan
- Reset, then read addr 1 → 8'h80; `rx_q_empty`=1, `tx_valid`=0, `baud_div`=16'd325.
- Write 8'hA5 to addr 0 with `tx_ready`=0 → `tx_valid`=1 and `tx_data`=8'hA5 next cycle. Pulse `tx_ready` → `tx_valid`=0.
- Write 9 bytes 8'h01..8'h09 with `tx_ready`=0 → `tx_q_full`=1 after the 8th. The 9th byte is dropped and drain order is 01..08.
- Strobe `rx_valid` with 8'h3C, then 8'hC3 → status = 8'h82. Reads of addr 0 return 3C, C3, then 00; `rx_q_empty`=1 after the second read.
- Write 8'h58 to addr 2 and 8'h14 to addr 3 → `baud_div`=16'h1458. Readback of addr 2/3 returns 58/14.
- With the TX queue holding 4 entries, a CPU write and `tx_ready` in the same cycle → count stays 4. Asserting `rst` mid-burst → status = 8'h80 next cycle.
